decode_queue: RTL and testbench



---
 rtl/rv32i_types.sv | 90 +++++++++
 rtl/rv32i_decoder.sv | 115 +++++++++++
 rtl/decode_queue.sv | 91 +++++++++
 tb/tb_decode_queue.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// ============================================================================
// Module      : rv32i_types
// Description : Shared RV32I encodings and the decoded-uop record for decode.
// Revision    : 1.0 - multi-wide decode queue types
// ============================================================================
`default_nettype none

package rv32i_types;

  typedef enum logic [6:0] {
    op_lui   = 7'b0110111,
    op_auipc = 7'b0010111,
    op_jal   = 7'b1101111,
    op_jalr  = 7'b1100111,
    op_br    = 7'b1100011,
    op_load  = 7'b0000011,
    op_store = 7'b0100011,
    op_imm   = 7'b0010011,
    op_reg   = 7'b0110011,
    op_csr   = 7'b1110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    beq = 3'b000, bne = 3'b001, blt = 3'b100,
    bge = 3'b101, bltu = 3'b110, bgeu = 3'b111
  } branch_funct3_t;

  typedef enum logic [2:0] {
    add = 3'b000, sll = 3'b001, slt = 3'b010, sltu = 3'b011,
    axor = 3'b100, sr = 3'b101, aor = 3'b110, aand = 3'b111
  } arith_funct3_t;

  typedef enum logic [2:0] {
    alu_add = 3'b000, alu_sll = 3'b001, alu_sra = 3'b010, alu_sub = 3'b011,
    alu_xor = 3'b100, alu_srl = 3'b101, alu_or  = 3'b110, alu_and = 3'b111
  } alu_ops;

  typedef enum logic {
    rs2_out = 1'b0,
    i_imm   = 1'b1
  } cmpmux_sel_t;

  typedef enum logic [3:0] {
    alu_out  = 4'd0, br_en = 4'd1, u_imm = 4'd2, lw = 4'd3, pc_plus4 = 4'd4,
    lb       = 4'd5, lbu   = 4'd6, lh    = 4'd7, lhu = 4'd8
  } regfilemux_sel_t;

  typedef enum logic [2:0] {
    fmt_none = 3'd0, fmt_i = 3'd1, fmt_s = 3'd2,
    fmt_b    = 3'd3, fmt_u = 3'd4, fmt_j = 3'd5
  } imm_fmt_t;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1_s;
    logic [4:0]      rs2_s;
    logic [4:0]      rd_s;
    logic [31:0]     imm;
    alu_ops          alu_op;
    branch_funct3_t  cmpop;
    cmpmux_sel_t     cmp_sel;
    regfilemux_sel_t regfilemux_sel;
    logic            regf_we;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            illegal;
  } decoded_uop_t;

  // Unknown opcodes map to fmt_none, which also yields a zero immediate.
  function automatic imm_fmt_t imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_t fmt;
    fmt = fmt_none;
    case (opcode)
      op_lui, op_auipc:                 fmt = fmt_u;
      op_jal:                           fmt = fmt_j;
      op_jalr, op_load, op_imm, op_csr: fmt = fmt_i;
      op_store:                         fmt = fmt_s;
      op_br:                            fmt = fmt_b;
      default:                          fmt = fmt_none;
    endcase
    return fmt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_decoder.sv
// ============================================================================
// Module      : rv32i_decoder
// Description : Combinational RV32I decoder producing one decoded_uop_t.
// Revision    : 1.0 - split out of the single-issue decode stage
// ============================================================================
`default_nettype none

module rv32i_decoder
  import rv32i_types::*;
(
  input  logic [31:0]  inst,
  input  logic [31:0]  pc,
  output decoded_uop_t uop
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_legal_op;
  logic       w_illegal;
  logic       w_uses_rs1;
  logic       w_uses_rs2;
  imm_fmt_t   w_fmt;

  assign w_opcode = inst[6:0];
  assign w_funct3 = inst[14:12];
  assign w_funct7 = inst[31:25];

  always_comb begin
    uop        = '0;
    w_legal_op = 1'b0;
    w_fmt      = imm_fmt_of(w_opcode);

    case (w_opcode)
      op_lui, op_auipc, op_jal, op_jalr, op_br,
      op_load, op_store, op_imm, op_reg, op_csr: w_legal_op = 1'b1;
      default:                                   w_legal_op = 1'b0;
    endcase

    // funct7 only qualifies register-register ops; 0x20 selects sub/sra.
    w_illegal = !w_legal_op ||
                ((w_opcode == op_reg) && (w_funct7 != 7'h00) && (w_funct7 != 7'h20)) ||
                ((w_opcode == op_reg) && (w_funct7 == 7'h20) &&
                 (w_funct3 != add) && (w_funct3 != sr));

    w_uses_rs1 = !((w_opcode == op_lui) || (w_opcode == op_auipc) || (w_opcode == op_jal));
    w_uses_rs2 = (w_opcode == op_reg) || (w_opcode == op_br) || (w_opcode == op_store);

    uop.pc       = pc;
    uop.inst     = inst;
    uop.opcode   = w_opcode;
    uop.funct3   = w_funct3;
    uop.funct7   = w_funct7;
    uop.rd_s     = inst[11:7];
    uop.rs1_s    = w_uses_rs1 ? inst[19:15] : 5'd0;
    uop.rs2_s    = w_uses_rs2 ? inst[24:20] : 5'd0;
    uop.uses_rs1 = w_uses_rs1;
    uop.uses_rs2 = w_uses_rs2;
    uop.illegal  = w_illegal;
    uop.regf_we  = !((w_opcode == op_br) || (w_opcode == op_store) ||
                     (inst[11:7] == 5'd0) || w_illegal);

    case (w_fmt)
      fmt_i:   uop.imm = {{21{inst[31]}}, inst[30:20]};
      fmt_s:   uop.imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
      fmt_b:   uop.imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      fmt_u:   uop.imm = {inst[31:12], 12'h000};
      fmt_j:   uop.imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      default: uop.imm = 32'h0;
    endcase

    uop.alu_op = alu_ops'(w_funct3);
    case (w_opcode)
      op_auipc, op_br, op_jal, op_jalr, op_load, op_store: uop.alu_op = alu_add;
      op_imm, op_reg: begin
        if (w_funct3 == sr)
          uop.alu_op = w_funct7[5] ? alu_sra : alu_srl;
        else if ((w_opcode == op_reg) && (w_funct3 == add) && w_funct7[5])
          uop.alu_op = alu_sub;
      end
      default: ;
    endcase

    uop.cmpop          = beq;
    uop.cmp_sel        = (w_opcode == op_imm) ? i_imm : rs2_out;
    uop.regfilemux_sel = alu_out;
    case (w_opcode)
      op_br:            uop.cmpop = branch_funct3_t'(w_funct3);
      op_lui:           uop.regfilemux_sel = u_imm;
      op_jal, op_jalr:  uop.regfilemux_sel = pc_plus4;
      op_load: begin
        case (w_funct3)
          3'b000:  uop.regfilemux_sel = lb;
          3'b001:  uop.regfilemux_sel = lh;
          3'b100:  uop.regfilemux_sel = lbu;
          3'b101:  uop.regfilemux_sel = lhu;
          default: uop.regfilemux_sel = lw;
        endcase
      end
      op_imm, op_reg: begin
        if (w_funct3 == slt) begin
          uop.cmpop          = blt;
          uop.regfilemux_sel = br_en;
        end else if (w_funct3 == sltu) begin
          uop.cmpop          = bltu;
          uop.regfilemux_sel = br_en;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_queue.sv
// ============================================================================
// Module      : decode_queue
// Description : Circular instruction queue decoding up to DEC_WIDTH heads/cycle.
// Revision    : 1.0 - multi-wide successor to the single-issue decode stage
// ============================================================================
`default_nettype none

module decode_queue
  import rv32i_types::*;
#(
  parameter int IQ_DEPTH  = 8,
  parameter int DEC_WIDTH = 2,
  parameter int CNT_W     = $clog2(IQ_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [31:0]                    in_inst,
  input  logic [31:0]                    in_pc,
  output logic [DEC_WIDTH-1:0]           out_valid,
  output decoded_uop_t [DEC_WIDTH-1:0]   out_uop,
  input  logic                           out_ready,
  output logic [CNT_W-1:0]               occupancy
);

  localparam int                c_PTR_W = $clog2(IQ_DEPTH);
  localparam logic [CNT_W-1:0]  c_DEC_W = CNT_W'(DEC_WIDTH);
  localparam logic [CNT_W-1:0]  c_DEPTH = CNT_W'(IQ_DEPTH);

  logic [31:0]        r_inst [IQ_DEPTH];
  logic [31:0]        r_pc   [IQ_DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic [CNT_W-1:0]   w_n_out;
  logic [CNT_W-1:0]   w_pop_n;

  // rst gates in_ready so fetch sees backpressure for the whole reset window.
  assign in_ready  = rst && (r_count < c_DEPTH);
  assign w_push    = in_valid && in_ready;
  assign w_n_out   = (r_count < c_DEC_W) ? r_count : c_DEC_W;
  assign w_pop     = out_ready && (w_n_out != '0);
  assign w_pop_n   = w_pop ? w_n_out : '0;
  assign occupancy = r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + c_PTR_W'(1);
      // n_out can equal IQ_DEPTH; truncation keeps the wrap correct.
      r_head  <= r_head + w_pop_n[c_PTR_W-1:0];
      r_count <= r_count + CNT_W'(w_push) - w_pop_n;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_inst[r_tail] <= in_inst;
      r_pc[r_tail]   <= in_pc;
    end
  end

  for (genvar gi = 0; gi < DEC_WIDTH; gi++) begin : g_slot
    logic [c_PTR_W-1:0] w_idx;

    assign w_idx         = r_head + c_PTR_W'(gi);
    assign out_valid[gi] = (CNT_W'(gi) < w_n_out);

    rv32i_decoder u_dec (
      .inst (r_inst[w_idx]),
      .pc   (r_pc[w_idx]),
      .uop  (out_uop[gi])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_queue.sv
// ============================================================================
// Module      : tb_decode_queue
// Description : Randomized queue-model bench for decode_queue plus decode checks.
// Revision    : 1.0 - initial bench
// ============================================================================
`default_nettype none

module tb_decode_queue;
  import rv32i_types::*;

  localparam int IQ_DEPTH  = 8;
  localparam int DEC_WIDTH = 2;
  localparam int CNT_W     = $clog2(IQ_DEPTH + 1);

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         flush = 1'b0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [31:0]                  in_inst = '0;
  logic [31:0]                  in_pc = '0;
  logic [DEC_WIDTH-1:0]         out_valid;
  decoded_uop_t [DEC_WIDTH-1:0] out_uop;
  logic                         out_ready = 1'b0;
  logic [CNT_W-1:0]             occupancy;

  always #5 clk = ~clk;

  decode_queue #(.IQ_DEPTH(IQ_DEPTH), .DEC_WIDTH(DEC_WIDTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_uop(out_uop), .out_ready(out_ready),
    .occupancy(occupancy)
  );

  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t mq[$];

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Immediates built from the RV32I field diagrams as signed values.
  function automatic logic [31:0] ref_imm(input logic [31:0] x);
    logic signed [12:0] b;
    logic signed [20:0] j;
    case (x[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: return 32'($signed(x[31:20]));
      7'h23: return 32'($signed({x[31:25], x[11:7]}));
      7'h63: begin b = {x[31], x[7], x[30:25], x[11:8], 1'b0}; return 32'(b); end
      7'h37, 7'h17: return x & 32'hFFFFF000;
      7'h6F: begin j = {x[31], x[19:12], x[20], x[30:21], 1'b0}; return 32'(j); end
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_illegal(input logic [31:0] x);
    logic [6:0] op;
    op = x[6:0];
    if (!(op inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73}))
      return 1'b1;
    if (op == 7'h33 && !(x[31:25] inside {7'h00, 7'h20})) return 1'b1;
    if (op == 7'h33 && x[31:25] == 7'h20 && !(x[14:12] inside {3'd0, 3'd5})) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] x;
    x = $urandom();
    case ($urandom_range(0, 10))
      0: x[6:0] = 7'h37;  1: x[6:0] = 7'h17;  2: x[6:0] = 7'h6F;  3: x[6:0] = 7'h67;
      4: x[6:0] = 7'h63;  5: x[6:0] = 7'h03;  6: x[6:0] = 7'h23;  7: x[6:0] = 7'h13;
      8: x[6:0] = 7'h33;  9: x[6:0] = 7'h73;  default: x[6:0] = 7'h7F;
    endcase
    if (x[6:0] == 7'h33 && $urandom_range(0, 2) != 0)
      x[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    return x;
  endfunction

  task automatic check_all();
    int n;
    logic [31:0] x;
    bit u1, u2, ill;
    n = (mq.size() < DEC_WIDTH) ? mq.size() : DEC_WIDTH;
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < IQ_DEPTH));
    chk("out_valid", 32'(out_valid), (32'd1 << n) - 32'd1);
    for (int k = 0; k < n; k++) begin
      x   = mq[k].inst;
      u1  = !(x[6:0] inside {7'h37, 7'h17, 7'h6F});
      u2  = x[6:0] inside {7'h33, 7'h63, 7'h23};
      ill = ref_illegal(x);
      chk($sformatf("slot%0d.pc", k), out_uop[k].pc, mq[k].pc);
      chk($sformatf("slot%0d.inst", k), out_uop[k].inst, x);
      chk($sformatf("slot%0d.imm", k), out_uop[k].imm, ref_imm(x));
      chk($sformatf("slot%0d.illegal", k), 32'(out_uop[k].illegal), 32'(ill));
      chk($sformatf("slot%0d.uses", k), {30'd0, out_uop[k].uses_rs1, out_uop[k].uses_rs2},
          {30'd0, u1, u2});
      chk($sformatf("slot%0d.rs", k), {17'd0, out_uop[k].rs1_s, out_uop[k].rs2_s, out_uop[k].rd_s},
          {17'd0, (u1 ? x[19:15] : 5'd0), (u2 ? x[24:20] : 5'd0), x[11:7]});
      chk($sformatf("slot%0d.regf_we", k), 32'(out_uop[k].regf_we),
          32'(!(x[6:0] inside {7'h63, 7'h23}) && x[11:7] != 5'd0 && !ill));
    end
  endtask

  // Advance one clock; the model applies the accept/retire rules on the same edge.
  task automatic step();
    int n;
    bit push, pop;
    push = in_valid && (mq.size() < IQ_DEPTH);
    n    = (mq.size() < DEC_WIDTH) ? mq.size() : DEC_WIDTH;
    pop  = out_ready && (n > 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (pop) for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (push) mq.push_back('{pc: in_pc, inst: in_inst});
    end
    #1;
    check_all();
  endtask

  task automatic load_one(input logic [31:0] inst);
    out_ready = 1'b0;
    flush = 1'b1; in_valid = 1'b0; step();
    flush = 1'b0; in_valid = 1'b1; in_inst = inst; in_pc = 32'h2000; step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    chk("rst.occupancy", 32'(occupancy), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_all();

    // single addi
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0; step();
    in_valid = 1'b0;
    chk("addi.valid", 32'(out_valid), 32'd1);
    chk("addi.rd", 32'(out_uop[0].rd_s), 32'd1);
    chk("addi.imm", out_uop[0].imm, 32'd5);
    chk("addi.we", 32'(out_uop[0].regf_we), 32'd1);
    chk("addi.rs2", 32'(out_uop[0].uses_rs2), 32'd0);
    out_ready = 1'b1; step(); out_ready = 1'b0;

    // fill to full, then drain while pushing; pointers wrap past entry 7
    for (int k = 0; k < IQ_DEPTH; k++) begin
      in_valid = 1'b1; in_inst = 32'h00000013 | (32'(k + 1) << 7); in_pc = 32'h1000 + 32'(4 * k);
      step();
    end
    chk("full.occ", 32'(occupancy), 32'd8);
    chk("full.ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int k = IQ_DEPTH; k < IQ_DEPTH + 12; k++) begin
      in_inst = 32'h00000013 | (32'(k % 31 + 1) << 7); in_pc = 32'h1000 + 32'(4 * k);
      step();
    end
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) step();
    chk("drain.occ", 32'(occupancy), 32'd0);

    // flush at occupancy 5 with an incoming instruction
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_inst = rand_inst(); in_pc = 32'h3000 + 32'(4 * k); step();
    end
    chk("preflush.occ", 32'(occupancy), 32'd5);
    flush = 1'b1; step();
    flush = 1'b0;
    chk("flush.occ", 32'(occupancy), 32'd0);
    chk("flush.valid", 32'(out_valid), 32'd0);
    in_inst = 32'h00000013; in_pc = 32'h100; step();
    in_valid = 1'b0;
    chk("flush.first_pc", out_uop[0].pc, 32'h100);

    // directed decode cases
    load_one(32'h402081B3);
    chk("sub.alu", 32'(out_uop[0].alu_op), 32'(alu_sub));
    chk("sub.rs2", 32'(out_uop[0].uses_rs2), 32'd1);
    load_one(32'h0020A423);
    chk("sw.imm", out_uop[0].imm, 32'd8);
    chk("sw.we", 32'(out_uop[0].regf_we), 32'd0);
    load_one(32'hFE000EE3);
    chk("beq.imm", out_uop[0].imm, 32'hFFFFFFFC);
    load_one(32'h00000013);
    chk("nop.we", 32'(out_uop[0].regf_we), 32'd0);
    load_one(32'h0000007F);
    chk("ill_op.illegal", 32'(out_uop[0].illegal), 32'd1);
    chk("ill_op.we", 32'(out_uop[0].regf_we), 32'd0);
    chk("ill_op.valid", 32'(out_valid), 32'd1);
    load_one(32'h022081B3);
    chk("ill_f7.illegal", 32'(out_uop[0].illegal), 32'd1);
    chk("ill_f7.we", 32'(out_uop[0].regf_we), 32'd0);
    chk("ill_f7.valid", 32'(out_valid), 32'd1);

    // asynchronous reset mid-cycle with three entries held
    flush = 1'b1; step(); flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_inst = rand_inst(); in_pc = 32'h4000 + 32'(4 * k); step();
    end
    in_valid = 1'b0;
    chk("pre_arst.occ", 32'(occupancy), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 32'd0);
    chk("arst.in_ready", 32'(in_ready), 32'd0);
    chk("arst.occ", 32'(occupancy), 32'd0);
    mq.delete();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check_all();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_inst   = rand_inst();
      in_pc     = $urandom() & 32'hFFFFFFFC;
      step();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
